// File: rtl/mips_dmem.sv
// Word-organised data memory behind a req/gnt/rvalid handshake with a fixed
// number of wait states between grant and the single-cycle response.
module mips_dmem #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
  localparam logic        HAS_WAIT  = (WAIT_STATES != 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_next_s;
  logic              we_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        be_r;
  logic              rvalid_r;
  logic              err_r;
  logic [31:0]       rdata_r;

  logic              cur_we_s;
  logic [31:0]       cur_addr_s;
  logic [31:0]       cur_wdata_s;
  logic [3:0]        cur_be_s;
  logic [32:0]       offset_s;
  logic              err_s;
  logic [IDX_W-1:0]  index_s;
  logic              enter_resp_s;
  logic              commit_s;

  logic [31:0]       mem [DEPTH_WORDS];

  assign gnt_o    = req_i & nrst & (state_r == ST_IDLE);
  assign busy_o   = (state_r != ST_IDLE);
  assign rvalid_o = rvalid_r;
  assign err_o    = err_r;
  assign rdata_o  = rdata_r;

  // Next-state and wait-counter logic
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_o) begin
          cnt_next_s   = WAIT_LOAD;
          state_next_s = HAS_WAIT ? ST_WAIT : ST_RESP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // With zero wait states the grant edge is also the RESP edge, so the
  // live inputs stand in for the not-yet-latched request fields.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_we_s    = we_i;
      cur_addr_s  = addr_i;
      cur_wdata_s = wdata_i;
      cur_be_s    = be_i;
    end else begin
      cur_we_s    = we_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_be_s    = be_r;
    end
  end

  // BASE_ADDR is word aligned, so the low offset bits give misalignment and
  // the borrow / upper bits give the out-of-range cases.
  assign offset_s     = {1'b0, cur_addr_s} - {1'b0, BASE_ADDR};
  assign err_s        = offset_s[32] | (|offset_s[31:IDX_W+2]) | (|offset_s[1:0]);
  assign index_s      = offset_s[IDX_W+1:2];
  assign enter_resp_s = (state_next_s == ST_RESP) && (state_r != ST_RESP);
  assign commit_s     = enter_resp_s & cur_we_s & ~err_s;

  // FSM state and wait counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Request fields captured at grant
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      we_r    <= 1'b0;
      addr_r  <= 32'h0;
      wdata_r <= 32'h0;
      be_r    <= 4'h0;
    end else if (gnt_o) begin
      we_r    <= we_i;
      addr_r  <= addr_i;
      wdata_r <= wdata_i;
      be_r    <= be_i;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      be_r    <= be_r;
    end
  end

  // Storage array, deliberately without reset
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be_s[b]) begin
          mem[index_s][8*b +: 8] <= cur_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Response registers, loaded on the edge entering RESP and cleared after
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0;
    end else if (enter_resp_s) begin
      rvalid_r <= 1'b1;
      err_r    <= err_s;
      rdata_r  <= (cur_we_s | err_s) ? 32'h0 : mem[index_s];
    end else begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0;
    end
  end

endmodule

// File: tb/tb_mips_dmem.sv
// Randomised and directed bench for mips_dmem with a behavioural word-array
// model; one instance uses 2 wait states, a second uses none.
module tb_mips_dmem;

  localparam longint unsigned BASE  = 64'h1000_0000;
  localparam longint unsigned DEPTH = 64'd1024;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } op_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req2 = 1'b0, req0 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [3:0]  be = 4'h0;
  logic        gnt2, rvalid2, err2, busy2;
  logic        gnt0, rvalid0, err0, busy0;
  logic [31:0] rdata2, rdata0;

  logic [31:0] m2 [1024];
  logic [31:0] m0 [1024];
  int n_cmp = 0;
  int n_fail = 0;

  mips_dmem #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
    .clk(clk), .nrst(nrst), .req_i(req2), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt2), .rvalid_o(rvalid2),
    .rdata_o(rdata2), .err_o(err2), .busy_o(busy2));

  mips_dmem #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .nrst(nrst), .req_i(req0), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt0), .rvalid_o(rvalid0),
    .rdata_o(rdata0), .err_o(err0), .busy_o(busy0));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic op_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b);
    op_t o;
    o.w = w; o.a = a; o.d = d; o.b = b;
    return o;
  endfunction

  // Reference model: plain word array, byte merge, range rules from the address map.
  task automatic model_op(input bit sel0, input op_t op, output logic [31:0] er, output logic ee);
    longint unsigned a;
    int idx;
    logic [31:0] word;
    a  = op.a;
    ee = (a % 4 != 0) || (a < BASE) || (a >= BASE + 4 * DEPTH);
    er = 32'h0;
    if (!ee) begin
      idx  = int'((a - BASE) / 4);
      word = sel0 ? m0[idx] : m2[idx];
      if (op.w) begin
        for (int b = 0; b < 4; b++) if (op.b[b]) word[8*b +: 8] = op.d[8*b +: 8];
        if (sel0) m0[idx] = word; else m2[idx] = word;
      end else begin
        er = word;
      end
    end
  endtask

  // One transfer on the chosen instance; reports grant, latency and response.
  task automatic do_xfer(input bit sel0, input op_t op, output logic g, output int lat,
                         output logic [31:0] rd, output logic e);
    @(negedge clk);
    we = op.w; addr = op.a; wdata = op.d; be = op.b;
    if (sel0) req0 = 1'b1; else req2 = 1'b1;
    #1 g = sel0 ? gnt0 : gnt2;
    @(posedge clk);
    #1 req0 = 1'b0; req2 = 1'b0;
    lat = 0; rd = 32'h0; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sel0 ? rvalid0 : rvalid2) begin
        lat = k; rd = sel0 ? rdata0 : rdata2; e = sel0 ? err0 : err2;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    req2 = 1'b1; req0 = 1'b1; we = 1'b0; addr = 32'h1000_0000;
    #1;
    n_cmp++;
    if ({gnt2, rvalid2, err2, busy2, rdata2} !== 36'h0) begin
      n_fail++; $display("FAIL reset_outputs_ws2: got %h expected 0", {gnt2, rvalid2, err2, busy2, rdata2});
    end
    n_cmp++;
    if ({gnt0, rvalid0, err0, busy0, rdata0} !== 36'h0) begin
      n_fail++; $display("FAIL reset_outputs_ws0: got %h expected 0", {gnt0, rvalid0, err0, busy0, rdata0});
    end
    @(negedge clk);
    nrst = 1'b1;
    #1;
    n_cmp++;
    if (gnt2 !== 1'b1) begin
      n_fail++; $display("FAIL first_grant_after_reset: got %b expected 1", gnt2);
    end
    @(posedge clk);
    #1 req2 = 1'b0; req0 = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (busy2 !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_drain: busy got %b expected 0", busy2);
    end
  endtask

  task automatic test_directed;
    op_t ops[$];
    logic g, e, ee; int lat; logic [31:0] rd, er;
    ops.push_back(mk(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF));
    ops.push_back(mk(1'b0, 32'h1000_0010, 32'h0, 4'h0));
    ops.push_back(mk(1'b1, 32'h1000_0014, 32'h1122_3344, 4'hF));
    ops.push_back(mk(1'b1, 32'h1000_0014, 32'hAABB_CCDD, 4'b0101));
    ops.push_back(mk(1'b0, 32'h1000_0014, 32'h0, 4'hF));
    ops.push_back(mk(1'b1, 32'h1000_0000, 32'h0BAD_F00D, 4'hF));
    ops.push_back(mk(1'b0, 32'h1000_0002, 32'h0, 4'hF));
    ops.push_back(mk(1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF));
    ops.push_back(mk(1'b1, 32'h1000_1000, 32'h5555_AAAA, 4'hF));
    ops.push_back(mk(1'b1, 32'h1000_0010, 32'h7777_7777, 4'h0));
    ops.push_back(mk(1'b0, 32'h1000_0000, 32'h0, 4'h0));
    ops.push_back(mk(1'b0, 32'h1000_0010, 32'h0, 4'h0));
    foreach (ops[i]) begin
      model_op(1'b0, ops[i], er, ee);
      do_xfer(1'b0, ops[i], g, lat, rd, e);
      n_cmp++;
      if (g !== 1'b1 || lat !== 3) begin
        n_fail++; $display("FAIL dir%0d_timing: gnt %b lat %0d expected gnt 1 lat 3", i, g, lat);
      end
      n_cmp++;
      if (rd !== er || e !== ee) begin
        n_fail++; $display("FAIL dir%0d_resp: rdata %h err %b expected %h %b", i, rd, e, er, ee);
      end
      if (i == 1 || i == 11) begin
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL dir%0d_deadbeef: got %h expected deadbeef", i, rd);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (rd !== 32'h11BB_33DD) begin
          n_fail++; $display("FAIL byte_merge: got %h expected 11bb33dd", rd);
        end
      end
    end
  endtask

  task automatic test_random;
    op_t op;
    logic g, e, ee; int lat; logic [31:0] rd, er, a;
    for (int i = 0; i < 57; i++) begin
      if (i < 17) begin
        a  = (i == 16) ? 32'h1000_0FFC : 32'h1000_0000 + 32'(4 * i);
        op = mk(1'b1, a, $urandom, 4'hF);
      end else begin
        case ($urandom_range(0, 5))
          0, 1, 2: a = 32'h1000_0000 + 32'(4 * $urandom_range(0, 15));
          3:       a = 32'h1000_0FFC;
          4:       a = 32'h1000_0000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
          default: a = $urandom_range(0, 1) ? 32'h1000_0000 - 32'(4 * $urandom_range(1, 8))
                                            : 32'h1000_1000 + 32'(4 * $urandom_range(0, 8));
        endcase
        op = mk(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
      model_op(1'b0, op, er, ee);
      do_xfer(1'b0, op, g, lat, rd, e);
      n_cmp++;
      if (g !== 1'b1 || lat !== 3 || rd !== er || e !== ee) begin
        n_fail++;
        $display("FAIL rand%0d: a %h w %b gnt %b lat %0d rdata %h err %b expected lat 3 rdata %h err %b",
                 i, op.a, op.w, g, lat, rd, e, er, ee);
      end
    end
  endtask

  task automatic test_back_to_back;
    int gcount, bcount;
    gcount = 0; bcount = 0;
    @(negedge clk);
    we = 1'b0; addr = 32'h1000_0010; be = 4'hF; req2 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      n_cmp++;
      if (gnt2 !== (k % 4 == 0) || busy2 !== (k % 4 != 0) || rvalid2 !== (k % 4 == 3)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: gnt %b busy %b rvalid %b expected %b %b %b", k, gnt2, busy2,
                 rvalid2, (k % 4 == 0), (k % 4 != 0), (k % 4 == 3));
      end
      gcount += int'(gnt2); bcount += int'(busy2);
      @(negedge clk);
    end
    req2 = 1'b0;
    n_cmp++;
    if (gcount != 4 || bcount != 12) begin
      n_fail++; $display("FAIL b2b_counts: gnt %0d busy %0d expected 4 12", gcount, bcount);
    end
  endtask

  task automatic test_ws0;
    op_t ops[$];
    logic g, e, ee; int lat; logic [31:0] rd, er;
    ops.push_back(mk(1'b1, 32'h1000_0FFC, $urandom, 4'hF));
    ops.push_back(mk(1'b1, 32'h1000_0000, $urandom, 4'hF));
    ops.push_back(mk(1'b0, 32'h1000_0FFC, 32'h0, 4'hF));
    ops.push_back(mk(1'b1, 32'h1000_0FFC, $urandom, 4'b1010));
    ops.push_back(mk(1'b0, 32'h1000_1000, 32'h0, 4'hF));
    ops.push_back(mk(1'b0, 32'h1000_0FFC, 32'h0, 4'hF));
    ops.push_back(mk(1'b0, 32'h1000_0000, 32'h0, 4'hF));
    foreach (ops[i]) begin
      model_op(1'b1, ops[i], er, ee);
      do_xfer(1'b1, ops[i], g, lat, rd, e);
      n_cmp++;
      if (g !== 1'b1 || lat !== 1 || rd !== er || e !== ee) begin
        n_fail++;
        $display("FAIL ws0_%0d: gnt %b lat %0d rdata %h err %b expected lat 1 rdata %h err %b",
                 i, g, lat, rd, e, er, ee);
      end
    end
  endtask

  task automatic test_reset_abort;
    logic g, e, ee; int lat, seen; logic [31:0] rd, er;
    model_op(1'b0, mk(1'b1, 32'h1000_0020, 32'h0, 4'hF), er, ee);
    do_xfer(1'b0, mk(1'b1, 32'h1000_0020, 32'h0, 4'hF), g, lat, rd, e);
    @(negedge clk);
    we = 1'b1; addr = 32'h1000_0020; wdata = 32'hCAFE_F00D; be = 4'hF; req2 = 1'b1;
    @(posedge clk);
    #1 req2 = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    n_cmp++;
    if ({gnt2, rvalid2, err2, busy2, rdata2} !== 36'h0) begin
      n_fail++; $display("FAIL abort_outputs: got %h expected 0", {gnt2, rvalid2, err2, busy2, rdata2});
    end
    @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(rvalid2);
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_no_rvalid: saw %0d strobes expected 0", seen);
    end
    model_op(1'b0, mk(1'b0, 32'h1000_0020, 32'h0, 4'hF), er, ee);
    do_xfer(1'b0, mk(1'b0, 32'h1000_0020, 32'h0, 4'hF), g, lat, rd, e);
    n_cmp++;
    if (lat !== 3 || rd !== 32'h0 || rd !== er || e !== 1'b0) begin
      n_fail++; $display("FAIL abort_not_committed: lat %0d rdata %h err %b expected 3 00000000 0", lat, rd, e);
    end
    model_op(1'b0, mk(1'b0, 32'h1000_0010, 32'h0, 4'hF), er, ee);
    do_xfer(1'b0, mk(1'b0, 32'h1000_0010, 32'h0, 4'hF), g, lat, rd, e);
    n_cmp++;
    if (lat !== 3 || rd !== er || e !== ee) begin
      n_fail++; $display("FAIL persist_after_reset: lat %0d rdata %h err %b expected 3 %h %b", lat, rd, e, er, ee);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ws0();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_dmem.md
MIPS_DMEM -- requirements
Module: mips_dmem

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h1000_0000, byte address of word 0.
REQ-002 Parameter: DEPTH_WORDS, default 1024, number of 32-bit words; power of two.
REQ-003 Parameter: WAIT_STATES, default 2, extra cycles between grant and response; range 0..15.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: nrst  input  1  reset, asynchronous, active-low.
REQ-006 Port: req_i  input  1  initiator requests a transfer.
REQ-007 Port: we_i  input  1  1 = write, 0 = read.
REQ-008 Port: addr_i  input  32  byte address.
REQ-009 Port: wdata_i  input  32  write data.
REQ-010 Port: be_i  input  4  byte enables; bit n enables wdata_i[8n+7:8n].
REQ-011 Port: gnt_o  output  1  request accepted this cycle.
REQ-012 Port: rvalid_o  output  1  one-cycle response strobe.
REQ-013 Port: rdata_o  output  32  read data; valid only while rvalid_o=1.
REQ-014 Port: err_o  output  1  response is an error; valid only while rvalid_o=1.
REQ-015 Port: busy_o  output  1  transfer in progress (state not IDLE).

Function
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 gnt_o SHALL be combinational: req_i & (state==IDLE).
REQ-018 On grant: latch we_i, addr_i, wdata_i, be_i; load wait counter with WAIT_STATES.
REQ-018a Grant transition: to WAIT if WAIT_STATES>0, else to RESP.
REQ-019 WAIT: counter decrements each cycle; on reaching 1, next state is RESP. req_i is ignored in WAIT.
REQ-020 RESP: rvalid_o=1 for exactly one cycle, then IDLE. req_i is ignored in RESP, and no grant is issued there.
REQ-021 Latency: grant in cycle N gives rvalid_o in cycle N+1+WAIT_STATES.
REQ-021a Maximum throughput is one transfer per WAIT_STATES+2 cycles.
REQ-022 Error condition: latched addr[1:0]!=0, or addr<BASE_ADDR, or addr>=BASE_ADDR+4*DEPTH_WORDS.
REQ-023 Word index = (addr-BASE_ADDR)>>2, width log2(DEPTH_WORDS); upper bits ignored once the range check passes.
REQ-024 Write commit: on the clock edge entering RESP, only for enabled bytes and only if no error.
REQ-024a be_i=4'b0000 write: no storage change; normal response with err_o=0.
REQ-025 Read response: rdata_o = stored word at index, sampled at RESP; all 4 bytes returned regardless of be_i.
REQ-026 Write responses: rdata_o=0.
REQ-027 Error responses: err_o=1, rdata_o=0, storage unchanged.
REQ-028 Outside RESP: rvalid_o=0, err_o=0, rdata_o=0.
REQ-029 Read after write: a read granted after a write's RESP cycle SHALL return the written data.

Reset
REQ-030 nrst=0 SHALL immediately force state=IDLE, counter=0, latched request fields=0.
REQ-030a Under reset, all outputs SHALL be 0 (gnt_o=0 while nrst=0).
REQ-031 Reset mid-transfer (WAIT or RESP) SHALL abort the transfer with no response.
REQ-031a A write aborted before the RESP edge SHALL NOT be committed.
REQ-032 Storage array SHALL NOT be reset; contents persist across reset.
REQ-033 After nrst rises, the first rising edge with req_i=1 SHALL be granted.

Verification
REQ-034 WAIT_STATES=2; write addr 32'h1000_0010, data 32'hDEAD_BEEF, be 4'hF -> gnt cycle N; rvalid at N+3, err=0, rdata=0; read same addr -> rvalid at M+3, rdata=32'hDEAD_BEEF.
REQ-035 Byte-enable merge: word holds 32'h1122_3344; write be=4'b0101, data 32'hAABB_CCDD; read -> 32'h11BB_33DD.
REQ-036 Errors, each -> err=1, rdata=0, storage unchanged:
  - read 32'h1000_0002 (misaligned)
  - read 32'h0FFF_FFFC (below base)
  - write 32'h1000_1000 (at top, DEPTH_WORDS=1024)
REQ-037 req_i held high continuously, WAIT_STATES=2 -> gnt_o pulses every 4 cycles; busy_o high 3 of every 4 cycles.
REQ-038 WAIT_STATES=0 -> rvalid one cycle after gnt; boundary word 32'h1000_0FFC writes and reads back correctly.
REQ-039 Reset mid-transfer:
  - nrst pulsed low during WAIT of a write to 32'h1000_0020 (old 32'h0) -> no rvalid, outputs 0.
  - Read of 32'h1000_0020 after reset -> 32'h0.
  - Data previously written at 32'h1000_0010 is still intact.
